// File: rtl/joy_pkg.sv
// joy_pkg: shared direction encoding and ADC mid-scale value for the joystick decoder.
package joy_pkg;
    typedef enum logic [1:0] {
        DIR_CENTER = 2'b00,
        DIR_LEFT   = 2'b01,
        DIR_RIGHT  = 2'b10
    } dir_t;
    localparam logic [11:0] MID_SCALE = 12'd2048;
endpackage

// File: rtl/adc_avg4.sv
// adc_avg4: 4-entry moving-average window with running sum; avg is the truncated mean.
module adc_avg4
    import joy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [11:0] sample,
    output logic [11:0] avg
);
    logic [3:0][11:0] win;
    logic [13:0]      sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win <= {4{MID_SCALE}};
            sum <= {MID_SCALE, 2'b00};
        end else if (sample_en) begin
            win <= {win[2:0], sample};
            sum <= sum - {2'b00, win[3]} + {2'b00, sample};
        end
    end

    assign avg = sum[13:2];
endmodule

// File: rtl/adc_joystick_decoder.sv
// adc_joystick_decoder: ADC result -> filtered, hysteretic, debounced LEFT/RIGHT move pulses
// with auto-repeat; fixed 3-clk latency from an accepted sample tick.
module adc_joystick_decoder
    import joy_pkg::*;
#(
    parameter int SAMPLE_DIV     = 50000,
    parameter int LO_ENTER       = 1024,
    parameter int LO_EXIT        = 1280,
    parameter int HI_ENTER       = 3072,
    parameter int HI_EXIT        = 2816,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_PERIOD  = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] result,
    output logic [1:0]  dir,
    output logic        move_left,
    output logic        move_right,
    output logic [11:0] avg
);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES);
    localparam logic [RW-1:0] DELAY   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD  = RW'(REPEAT_PERIOD);
    localparam logic [11:0]   LO_EN   = 12'(LO_ENTER);
    localparam logic [11:0]   LO_EX   = 12'(LO_EXIT);
    localparam logic [11:0]   HI_EN   = 12'(HI_ENTER);
    localparam logic [11:0]   HI_EX   = 12'(HI_EXIT);

    logic [11:0]   r1, r2;
    logic [DW-1:0] div;
    logic          tick, acc, eval;
    dir_t          zone, zone_nx, cand, dir_q;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rep;
    logic          commit, rep_fire;

    assign tick = div == DIV_MAX;

    // result changes asynchronously; a tick only counts when two successive captures agree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1   <= MID_SCALE;
            r2   <= MID_SCALE;
            div  <= '0;
            acc  <= 1'b0;
            eval <= 1'b0;
        end else begin
            r1   <= result;
            r2   <= r1;
            div  <= tick ? '0 : div + 1'b1;
            acc  <= tick && (r1 == r2);
            eval <= acc;
        end
    end

    adc_avg4 u_avg (
        .clk       (clk),
        .reset     (reset),
        .sample_en (acc),
        .sample    (r2),
        .avg       (avg)
    );

    assign zone_nx = (zone == DIR_LEFT)  ? (avg > HI_EN ? DIR_RIGHT : avg >= LO_EX ? DIR_CENTER : DIR_LEFT) :
                     (zone == DIR_RIGHT) ? (avg < LO_EN ? DIR_LEFT : avg <= HI_EX ? DIR_CENTER : DIR_RIGHT) :
                                           (avg < LO_EN ? DIR_LEFT : avg > HI_EN ? DIR_RIGHT : DIR_CENTER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone <= DIR_CENTER;
            cand <= DIR_CENTER;
            cnt  <= '0;
        end else if (eval) begin
            zone <= zone_nx;
            if (zone_nx == cand) begin
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end else begin
                cand <= zone_nx;
                cnt  <= CW'(1);
            end
        end
    end

    assign commit   = (cnt == CNT_MAX) && (cand != dir_q);
    assign rep_fire = tick && (dir_q != DIR_CENTER) && (rep == RW'(1));

    // a commit overrides a coinciding repeat so only one pulse is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q      <= DIR_CENTER;
            rep        <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else if (commit) begin
            dir_q      <= cand;
            rep        <= (cand == DIR_CENTER) ? '0 : DELAY;
            move_left  <= cand == DIR_LEFT;
            move_right <= cand == DIR_RIGHT;
        end else begin
            move_left  <= rep_fire && (dir_q == DIR_LEFT);
            move_right <= rep_fire && (dir_q == DIR_RIGHT);
            if (tick && dir_q != DIR_CENTER) rep <= (rep == RW'(1)) ? PERIOD : rep - 1'b1;
        end
    end

    assign dir = dir_q;
endmodule

// File: tb/tb_adc_joystick_decoder.sv
// tb_adc_joystick_decoder: scenario tasks checked against a sample-level reference model.
module tb_adc_joystick_decoder;
    localparam int DIV = 4, STB = 2, DLY = 3, PER = 2;
    localparam int LO_ENTER = 1024, LO_EXIT = 1280, HI_ENTER = 3072, HI_EXIT = 2816;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] result = 12'd2048;
    logic [1:0]  dir;
    logic        move_left, move_right;
    logic [11:0] avg;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    adc_joystick_decoder #(
        .SAMPLE_DIV(DIV), .STABLE_SAMPLES(STB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) dut (
        .clk(clk), .reset(reset), .result(result),
        .dir(dir), .move_left(move_left), .move_right(move_right), .avg(avg)
    );

    // reference model: edge index k since reset, sample history, window queue, scheduled outputs
    int k, p1, p2, s, win[$];
    int m_avg, pend_avg_edge, pend_avg_val, pend_cmt_edge, pend_cmt_dir;
    int zone, cand, cnt, dir_tgt, m_dir, m_l, m_r, ticks;
    bit tk;

    function automatic int zone_of(int z, int a);
        if (z == 1) return a > HI_ENTER ? 2 : (a >= LO_EXIT ? 0 : 1);
        if (z == 2) return a < LO_ENTER ? 1 : (a <= HI_EXIT ? 0 : 2);
        return a < LO_ENTER ? 1 : (a > HI_ENTER ? 2 : 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k = 0; p1 = 2048; p2 = 2048; win = {2048, 2048, 2048, 2048};
            m_avg = 2048; pend_avg_edge = -1; pend_cmt_edge = -1;
            zone = 0; cand = 0; cnt = 0; dir_tgt = 0; m_dir = 0; m_l = 0; m_r = 0; ticks = 0;
        end else begin
            tk = (k % DIV) == DIV - 1;
            m_l = 0; m_r = 0;
            if (pend_avg_edge == k) m_avg = pend_avg_val;
            if (pend_cmt_edge == k) begin
                m_dir = pend_cmt_dir; m_l = int'(m_dir == 1); m_r = int'(m_dir == 2); ticks = 0;
            end else if (tk && m_dir != 0) begin
                ticks++;
                if (ticks >= DLY && (ticks - DLY) % PER == 0) begin
                    m_l = int'(m_dir == 1); m_r = int'(m_dir == 2);
                end
            end
            if (tk && p1 == p2) begin
                win.push_back(p1); void'(win.pop_front());
                s = 0;
                foreach (win[i]) s += win[i];
                pend_avg_edge = k + 1; pend_avg_val = s / 4;
                zone = zone_of(zone, s / 4);
                if (zone == cand) cnt = cnt < STB ? cnt + 1 : STB;
                else begin cand = zone; cnt = 1; end
                if (cnt == STB && cand != dir_tgt) begin
                    dir_tgt = cand; pend_cmt_edge = k + 3; pend_cmt_dir = cand;
                end
            end
            p2 = p1; p1 = int'(result);
            k++;
        end
    end

    function automatic logic [15:0] model_out();
        return {m_dir[1:0], m_l[0], m_r[0], m_avg[11:0]};
    endfunction

    function automatic logic [15:0] dut_out();
        return {dir, move_left, move_right, avg};
    endfunction

    task automatic test_reset();
        int pulses = 0;
        reset = 1'b1; result = 12'd2048;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_out() !== 16'h0800) begin
            errors++; $display("FAIL reset_state dut=%h exp=%h", dut_out(), 16'h0800);
        end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL reset_idle t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            pulses += int'(move_left) + int'(move_right);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_no_pulse got=%0d exp=0", pulses); end
    endtask

    task automatic test_left_step();
        int seen[$];
        int lp = 0, rp = 0;
        logic [11:0] last;
        last = avg; result = 12'd0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL left_step t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            if (avg !== last) begin seen.push_back(int'(avg)); last = avg; end
            lp += int'(move_left); rp += int'(move_right);
        end
        checks++;
        if (seen.size() < 3 || seen[0] != 1536 || seen[1] != 1024 || seen[2] != 512) begin
            errors++; $display("FAIL avg_steps got=%0d,%0d,%0d exp=1536,1024,512", seen[0], seen[1], seen[2]);
        end
        checks++;
        if (dir !== 2'b01) begin errors++; $display("FAIL left_commit dir=%0d exp=1", dir); end
        checks++;
        if (lp < 5 || rp != 0) begin errors++; $display("FAIL left_repeat left=%0d right=%0d exp >=5,0", lp, rp); end
    endtask

    task automatic test_band_hold();
        int lp = 0, late = 0;
        result = 12'd1200;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL band_hold t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            lp += int'(move_left);
        end
        checks++;
        if (dir !== 2'b01 || lp == 0) begin errors++; $display("FAIL band_left dir=%0d pulses=%0d exp 1,>0", dir, lp); end
        result = 12'd2048;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL band_exit t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            if (i >= 40) late += int'(move_left) + int'(move_right);
        end
        checks++;
        if (dir !== 2'b00 || late != 0) begin errors++; $display("FAIL center_exit dir=%0d pulses=%0d exp 0,0", dir, late); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out() || avg !== 12'd2048 || dir !== 2'b00) begin
                errors++; $display("FAIL drop t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            result = (i % 2 == 0) ? 12'd4095 : 12'd0;
        end
    endtask

    task automatic test_right_to_left();
        int direct = 0, saw_c = 0;
        logic [1:0] prev;
        result = 12'd4095;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL right_hold t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
        end
        checks++;
        if (dir !== 2'b10) begin errors++; $display("FAIL right_commit dir=%0d exp=2", dir); end
        prev = dir; result = 12'd0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL right_to_left t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            if (prev == 2'b10 && dir == 2'b01) begin
                direct++;
                checks++;
                if ({move_left, move_right} !== 2'b10) begin
                    errors++; $display("FAIL direct_pulse got=%b exp=10", {move_left, move_right});
                end
            end
            if (dir == 2'b00) saw_c = 1;
            prev = dir;
        end
        checks++;
        if (direct != 1 || saw_c != 0) begin errors++; $display("FAIL direct_commit n=%0d center=%0d exp 1,0", direct, saw_c); end
    endtask

    task automatic test_reset_mid();
        int lp = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL pre_reset t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_out() !== 16'h0800) begin errors++; $display("FAIL mid_reset dut=%h exp=%h", dut_out(), 16'h0800); end
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL post_reset t=%0t dut=%h model=%h", $time, dut_out(), model_out());
            end
            if ((move_left || move_right) && lp == 0) begin
                checks++;
                if (dir !== 2'b01 || move_right) begin
                    errors++; $display("FAIL first_pulse dir=%0d r=%0b exp 1,0", dir, move_right);
                end
            end
            lp += int'(move_left);
        end
        checks++;
        if (dir !== 2'b01 || lp == 0) begin errors++; $display("FAIL relock dir=%0d pulses=%0d exp 1,>0", dir, lp); end
    endtask

    task automatic test_random();
        int vals[11] = '{0, 1023, 1024, 1279, 1280, 2048, 2816, 2817, 3072, 3073, 4095};
        int v, len;
        bit noisy;
        for (int seg = 0; seg < 30; seg++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : vals[$urandom_range(0, 10)];
            len = $urandom_range(8, 60);
            noisy = $urandom_range(0, 4) == 0;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++; $display("FAIL random seg=%0d t=%0t dut=%h model=%h", seg, $time, dut_out(), model_out());
                end
                result = (noisy && i % 2 == 1) ? 12'($urandom_range(0, 4095)) : 12'(v);
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        test_reset();
        test_left_step();
        test_band_hold();
        test_drop();
        test_right_to_left();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
